// File: rtl/systolic_mem_responder_pkg.sv
// Shared types for the systolic memory responder: FSM state encoding and
// the fixed width of host and NPU word addresses.
package SystolicTypes;

  localparam int ADDR_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } sysmem_state_t;

endpackage

// File: rtl/systolic_mem_responder_if.sv
// Host and NPU signal bundle for the systolic memory responder.
// The master modport is the host/NPU side; the slave modport is the responder.
interface systolic_mem_responder_if #(
  parameter int WIDTH = 16
);

  logic                            host_we;
  logic                            host_re;
  logic [SystolicTypes::ADDR_W-1:0] host_addr;
  logic [WIDTH-1:0]                host_wdata;
  logic                            host_start;
  logic [WIDTH-1:0]                host_rdata;
  logic                            host_rvalid;
  logic                            host_ready;

  logic [SystolicTypes::ADDR_W-1:0] act_addr;
  logic                            mem_write;
  logic [WIDTH-1:0]                mem_data_write;
  logic [WIDTH-1:0]                mem_read;
  logic                            new_data;
  logic                            npu_done;

  logic                            timeout;
  logic                            err;

  modport master (
    output host_we, host_re, host_addr, host_wdata, host_start,
    output act_addr, mem_write, mem_data_write, npu_done,
    input  host_rdata, host_rvalid, host_ready, mem_read, new_data,
    input  timeout, err
  );

  modport slave (
    input  host_we, host_re, host_addr, host_wdata, host_start,
    input  act_addr, mem_write, mem_data_write, npu_done,
    output host_rdata, host_rvalid, host_ready, mem_read, new_data,
    output timeout, err
  );

endinterface

// File: rtl/systolic_mem_responder_ram.sv
// Shared word storage for the responder. One write port and one muxed
// address; the read side has a separate output register per requester so
// the NPU read data can hold while the host reads, and vice versa.
// Writes land after the read sample, so a same-address read sees old data.
module sysmem_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] addr,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_host_en,
  input  logic             rd_npu_en,
  input  logic             rd_zero,
  output logic [WIDTH-1:0] rdata_host,
  output logic [WIDTH-1:0] rdata_npu
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array; deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Registered read data, one holding register per requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_host <= '0;
      rdata_npu  <= '0;
    end else begin
      if (rd_host_en) begin
        rdata_host <= rd_zero ? '0 : mem[addr];
      end
      if (rd_npu_en) begin
        rdata_npu <= rd_zero ? '0 : mem[addr];
      end
    end
  end

endmodule

// File: rtl/systolic_mem_responder.sv
// Systolic memory responder: arbitrates one word array between a host port
// (IDLE only) and an NPU port (RUN only), launches NPU operations and
// guards each run with a watchdog.
// Optional feature macro: SYSMEM_BOUNDS_CHECK_EN (out-of-range accesses
// flag err and are dropped / read as 0; otherwise addresses wrap).
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | host owns memory, host_ready=1, waits for host_start
// ST_START | one-cycle new_data pulse to the NPU
// ST_RUN   | NPU owns memory until npu_done or watchdog expiry
module systolic_mem_responder
  import SystolicTypes::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 64,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  systolic_mem_responder_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  sysmem_state_t     state;
  logic [7:0]        wd_cnt;
  logic              host_ready_q;
  logic              new_data_q;
  logic              timeout_q;
  logic              rvalid_q;

  logic [ADDR_W-1:0] raw_addr;
  logic [WIDTH-1:0]  mux_wdata;
  logic              wr_req;
  logic              rd_host;
  logic              rd_npu;
  logic [IDX_W-1:0]  ram_idx;
  logic              oob;
  logic              start_acc;

  // Owner mux: the host drives the port in IDLE, the NPU in RUN, nobody in START.
  always_comb begin
    raw_addr  = bus.host_addr;
    mux_wdata = bus.host_wdata;
    wr_req    = 1'b0;
    rd_host   = 1'b0;
    rd_npu    = 1'b0;
    case (state)
      ST_IDLE: begin
        wr_req  = bus.host_we;
        rd_host = bus.host_re & ~bus.host_we;
      end
      ST_RUN: begin
        raw_addr  = bus.act_addr;
        mux_wdata = bus.mem_data_write;
        wr_req    = bus.mem_write;
        rd_npu    = 1'b1;
      end
      default: ;
    endcase
  end

  assign start_acc = (state == ST_IDLE) & bus.host_start;

`ifdef SYSMEM_BOUNDS_CHECK_EN
  logic err_q;

  assign oob     = int'(raw_addr) >= DEPTH;
  assign ram_idx = IDX_W'(raw_addr);

  // Sticky out-of-range flag; a fresh start clears history but still
  // records a bad access made in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (start_acc) begin
      err_q <= oob & (wr_req | rd_host);
    end else if (oob & (wr_req | rd_host | rd_npu)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign oob     = 1'b0;
  assign ram_idx = IDX_W'(int'(raw_addr) % DEPTH);
  assign bus.err = 1'b0;
`endif

  sysmem_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk        (clk),
    .rst        (rst),
    .addr       (ram_idx),
    .we         (wr_req & ~oob & ~rst),
    .wdata      (mux_wdata),
    .rd_host_en (rd_host),
    .rd_npu_en  (rd_npu),
    .rd_zero    (oob),
    .rdata_host (bus.host_rdata),
    .rdata_npu  (bus.mem_read)
  );

  // Sequencing FSM with watchdog and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      wd_cnt       <= '0;
      host_ready_q <= 1'b1;
      new_data_q   <= 1'b0;
      timeout_q    <= 1'b0;
      rvalid_q     <= 1'b0;
    end else begin
      rvalid_q   <= rd_host;
      new_data_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.host_start) begin
            state        <= ST_START;
            new_data_q   <= 1'b1;
            host_ready_q <= 1'b0;
            timeout_q    <= 1'b0;
          end
        end
        ST_START: begin
          state  <= ST_RUN;
          wd_cnt <= '0;
        end
        ST_RUN: begin
          // npu_done is checked first so a completion on the last allowed
          // cycle never reports a timeout.
          if (bus.npu_done) begin
            state        <= ST_IDLE;
            host_ready_q <= 1'b1;
          end else if (wd_cnt == 8'(TIMEOUT - 1)) begin
            state        <= ST_IDLE;
            host_ready_q <= 1'b1;
            timeout_q    <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        default: begin
          state        <= ST_IDLE;
          host_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.host_ready  = host_ready_q;
  assign bus.new_data    = new_data_q;
  assign bus.timeout     = timeout_q;
  assign bus.host_rvalid = rvalid_q;

endmodule

// File: doc/systolic_mem_responder.md
SYSTOLIC_MEM_RESPONDER -- requirements
Module: systolic_mem_responder

Interface
REQ-001 Parameter WIDTH, default 16: data word width, signed two's complement.
REQ-002 Parameter DEPTH, default 64: number of memory words.
REQ-003 Parameter TIMEOUT, default 255: maximum RUN cycles before forced abort, range 1..255.
REQ-004 clk  in  1  sole clock; all logic is rising-edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 host_we  in  1  host write strobe.
REQ-007 host_re  in  1  host read strobe.
REQ-008 host_addr  in  12  host word address.
REQ-009 host_wdata  in  WIDTH  host write data.
REQ-010 host_start  in  1  request one NPU operation.
REQ-011 host_rdata  out  WIDTH  host read data.
REQ-012 host_rvalid  out  1  host_rdata valid.
REQ-013 host_ready  out  1  host may access memory.
REQ-014 act_addr  in  12  NPU word address, read and write.
REQ-015 mem_write  in  1  NPU write strobe.
REQ-016 mem_data_write  in  WIDTH  NPU write data.
REQ-017 mem_read  out  WIDTH  NPU read data.
REQ-018 new_data  out  1  start pulse to NPU.
REQ-019 npu_done  in  1  NPU finished its operation (pulse).
REQ-020 timeout  out  1  sticky flag: RUN aborted by watchdog.
REQ-021 err  out  1  sticky flag: out-of-range access (macro-dependent, see Configuration).

Function
REQ-022 Memory SHALL be a single DEPTH x WIDTH array owned either by the host or by the NPU, never both at once.
REQ-023 FSM states SHALL be IDLE, START, RUN.
REQ-024 IDLE: host_ready=1; host_start -> START.
REQ-025 START: new_data=1 for exactly this one cycle; the state then moves unconditionally to RUN.
REQ-026 RUN: host_ready=0; npu_done -> IDLE; when the watchdog counter reaches TIMEOUT -> IDLE and timeout is set.
REQ-027 The watchdog counter SHALL clear on entry to RUN and increment once per RUN cycle.
REQ-028 Host writes SHALL commit on the edge where host_we=1 in IDLE.
REQ-029 Host reads SHALL register host_rdata=mem[host_addr] with host_rvalid=1 one cycle after host_re=1 in IDLE; host_rvalid is 0 otherwise.
REQ-030 host_we and host_re asserted together: the write wins, with no rvalid.
REQ-031 host_start together with host_we: the write commits, then START is entered.
REQ-032 host_we, host_re and host_start SHALL be ignored in START and RUN, with no side effects.
REQ-033 In RUN, mem_read SHALL equal mem[act_addr] registered one cycle after act_addr is sampled.
REQ-034 In RUN, mem_write=1 SHALL commit mem_data_write at act_addr.
REQ-035 NPU read data outside RUN SHALL hold its last value; NPU writes outside RUN SHALL be ignored.
REQ-036 A read and a write to the same address in the same cycle SHALL return the old data (read-before-write).
REQ-037 npu_done and a watchdog expiry in the same cycle: done takes priority and timeout stays clear.

Reset
REQ-038 Reset SHALL set the state to IDLE, the watchdog to 0, and host_rdata, host_rvalid, mem_read, new_data, timeout and err to 0.
REQ-039 Reset SHALL leave memory contents unchanged.
REQ-040 Reset during RUN SHALL abort to IDLE, with host_ready=1 on the next cycle.
REQ-041 The sticky flags SHALL clear only on reset, or when host_start is accepted.

Configuration
REQ-042 With SYSMEM_BOUNDS_CHECK_EN defined: any access with address >= DEPTH SHALL set err, writes to it are dropped, and reads return 0.
REQ-043 With SYSMEM_BOUNDS_CHECK_EN undefined: addresses SHALL wrap modulo DEPTH and err is tied to 0.

Structure
REQ-044 The package SystolicTypes SHALL hold the responder state enum (sysmem_state_t) and the constant ADDR_W=12.
REQ-045 The storage array SHALL be one sub-module, sysmem_ram: single write port, registered read, with a muxed address and write enable.

Verification
REQ-046 Reset -> all outputs 0 and host_ready=1.
REQ-047 Host writes 1..16 at 16..31, then reads 20 -> host_rdata=5, host_rvalid=1 one cycle later.
REQ-048 host_start -> new_data high for one cycle; in RUN, act_addr=17 -> mem_read=2 next cycle; host_we to 17 is ignored.
REQ-049 In RUN, mem_write with act_addr=48, data=-7; then npu_done; then a host read of 48 -> -7.
REQ-050 TIMEOUT=4 with no npu_done -> IDLE after 4 RUN cycles and timeout=1; the next host_start clears it.
REQ-051 Macro defined: host write to address 100 -> err=1 and address 36 unchanged. Macro undefined: the same write lands at 36 and err=0.
